// File: rtl/mem_responder.sv
// Memory-side responder: captures a MAR/MDR request, waits WAIT_STATES cycles, then
// performs a big-endian byte/halfword/word access on internal RAM and answers with MOC.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  DS,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MOC,
  output logic        ERR
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              moc_q, moc_d;
  logic              err_q, err_d;
  logic [31:0]       dout_q, dout_d;

  logic              rw_q;
  logic [1:0]        ds_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;

  logic              capture;
  logic              commit;
  logic              acc_err;
  logic [1:0]        off;
  logic [IDX_W-1:0]  wr_idx;
  logic [3:0][7:0]   rd_lanes;
  logic [3:0][7:0]   wr_lanes;
  logic [3:0]        we_lanes;
  logic [31:0]       rd_val;

  assign off      = addr_q[1:0];
  assign wr_idx   = addr_q[ADDR_W-1:2];
  assign capture  = (state_q == IDLE) && MOV;
  assign DATA_OUT = dout_q;
  assign MOC      = moc_q;
  assign ERR      = err_q;

  // RAM is split into four byte lanes; lane n holds every byte whose address ends in n.
  // The read is registered at the capture edge, which is always before the commit edge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] bank [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge CLK) begin
      if (we_lanes[gi]) bank[wr_idx] <= wr_lanes[gi];
      if (capture) rd_q <= bank[ADDR[ADDR_W-1:2]];
    end

    assign rd_lanes[gi] = rd_q;
  end

  always_ff @(posedge CLK) begin
    if (capture) begin
      rw_q    <= RW;
      ds_q    <= DS;
      addr_q  <= ADDR;
      wdata_q <= DATA_IN;
    end
  end

  always_comb begin
    acc_err = |addr_q[31:ADDR_W];
    case (ds_q)
      2'b01:   if (off[0]) acc_err = 1'b1;
      2'b10:   if (off != 2'b00) acc_err = 1'b1;
      2'b11:   acc_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (ds_q)
      2'b00:   rd_val = {24'd0, rd_lanes[off]};
      2'b01:   rd_val = {16'd0, rd_lanes[{off[1], 1'b0}], rd_lanes[{off[1], 1'b1}]};
      2'b10:   rd_val = {rd_lanes[0], rd_lanes[1], rd_lanes[2], rd_lanes[3]};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    we_lanes = '0;
    wr_lanes = '0;
    case (ds_q)
      2'b00: begin
        we_lanes[off] = 1'b1;
        wr_lanes[off] = wdata_q[7:0];
      end
      2'b01: begin
        we_lanes[{off[1], 1'b0}] = 1'b1;
        we_lanes[{off[1], 1'b1}] = 1'b1;
        wr_lanes[{off[1], 1'b0}] = wdata_q[15:8];
        wr_lanes[{off[1], 1'b1}] = wdata_q[7:0];
      end
      2'b10: begin
        we_lanes = 4'hF;
        wr_lanes = {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]};
      end
      default: ;
    endcase
    // Reset wins over a commit landing on the same edge.
    if (!commit || rw_q || acc_err || RESET) we_lanes = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    moc_d   = moc_q;
    err_d   = err_q;
    dout_d  = dout_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MOV) begin
          state_d = BUSY;
          cnt_d   = WAIT_INIT;
        end
      end
      BUSY: begin
        if (!MOV) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          moc_d   = 1'b1;
          err_d   = acc_err;
          state_d = DONE;
          if (rw_q) dout_d = acc_err ? 32'd0 : rd_val;
        end
      end
      DONE: begin
        if (!MOV) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states and one with none,
// each checked against a byte-array model of the big-endian RAM.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        srst;
  logic [1:0]  mov;
  logic        rw;
  logic [1:0]  ds;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] dout [2];
  logic [1:0]  moc;
  logic [1:0]  err;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .WAIT_STATES(2)) u_ws2 (
    .CLK(clk), .RESET(srst), .MOV(mov[0]), .RW(rw), .DS(ds), .ADDR(addr),
    .DATA_IN(wdata), .DATA_OUT(dout[0]), .MOC(moc[0]), .ERR(err[0])
  );

  mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_ws0 (
    .CLK(clk), .RESET(srst), .MOV(mov[1]), .RW(rw), .DS(ds), .ADDR(addr),
    .DATA_IN(wdata), .DATA_OUT(dout[1]), .MOC(moc[1]), .ERR(err[1])
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ref_mem [2][256];
  logic [31:0] exp_dout [2];
  int          exp_lat [2] = '{3, 1};

  int          got_lat;
  logic [31:0] got_d;
  logic        got_e;
  logic        got_rel;
  logic        exp_e;

  // Reference: bytes are stored individually, multi-byte values assembled MSB first.
  function automatic void ref_access(input int d, input logic rw_v, input logic [1:0] ds_v,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic e);
    int n;
    logic [31:0] v;
    n = 1 << ds_v;
    e = (ds_v == 2'd3) || (ds_v == 2'd1 && a[0]) || (ds_v == 2'd2 && a[1:0] != 2'd0) || (a > 32'd255);
    if (e) begin
      if (rw_v) exp_dout[d] = 32'd0;
      return;
    end
    if (rw_v) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[d][int'(a) + i]);
      exp_dout[d] = v;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[d][int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
    end
  endfunction

  // Drives one full handshake, scrambling the request inputs after capture.
  task automatic txn(input int d, input logic rw_v, input logic [1:0] ds_v,
                     input logic [31:0] a, input logic [31:0] wd);
    ref_access(d, rw_v, ds_v, a, wd, exp_e);
    @(negedge clk);
    rw = rw_v; ds = ds_v; addr = a; wdata = wd; mov[d] = 1'b1;
    @(posedge clk); #1;
    rw = 1'($urandom); ds = 2'($urandom); addr = $urandom; wdata = $urandom;
    got_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (moc[d]) begin
        got_lat = i;
        break;
      end
    end
    got_d = dout[d];
    got_e = err[d];
    @(negedge clk);
    mov[d] = 1'b0;
    @(posedge clk); #1;
    got_rel = !moc[d] && !err[d];
    $display("txn dut=%0d %s ds=%0d addr=%h wdata=%h -> lat=%0d err=%0b data=%h",
             d, rw_v ? "RD" : "WR", ds_v, a, wd, got_lat, got_e, got_d);
  endtask

  task automatic test_reset();
    srst = 1'b1; mov = 2'b00; rw = 1'b0; ds = 2'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (moc[d] !== 1'b0 || err[d] !== 1'b0 || dout[d] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_state dut=%0d: got moc=%b err=%b data=%h, expected 0/0/0", d, moc[d], err[d], dout[d]);
      end
      exp_dout[d] = 32'd0;
    end
    @(negedge clk);
    srst = 1'b0;
  endtask

  task automatic init_mem();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++) txn(d, 1'b0, 2'd2, 32'(w * 4), $urandom);
  endtask

  task automatic test_basic();
    logic [7:0] bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    txn(0, 1'b0, 2'd2, 32'h10, 32'hDEADBEEF);
    vectors++;
    if (got_lat !== 3 || got_e !== 1'b0 || got_rel !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_write: got lat=%0d err=%b rel=%b, expected 3/0/1", got_lat, got_e, got_rel);
    end
    txn(0, 1'b1, 2'd2, 32'h10, 32'h0);
    vectors++;
    if (got_d !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL basic_word_read: got %h expected deadbeef", got_d);
    end
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'b1, 2'd0, 32'(16 + i), 32'h0);
      vectors++;
      if (got_d !== {24'd0, bytes[i]}) begin
        miscompares++;
        $display("FAIL basic_byte_read%0d: got %h expected %h", i, got_d, {24'd0, bytes[i]});
      end
    end
    txn(0, 1'b1, 2'd1, 32'h12, 32'h0);
    vectors++;
    if (got_d !== 32'h0000BEEF) begin
      miscompares++;
      $display("FAIL basic_half_read: got %h expected 0000beef", got_d);
    end
    txn(0, 1'b0, 2'd0, 32'h11, 32'hFFFFFF55);
    txn(0, 1'b1, 2'd2, 32'h10, 32'h0);
    vectors++;
    if (got_d !== 32'hDE55BEEF) begin
      miscompares++;
      $display("FAIL basic_byte_write: got %h expected de55beef", got_d);
    end
  endtask

  task automatic test_errors();
    txn(0, 1'b0, 2'd2, 32'h21, 32'h12345678);
    vectors++;
    if (got_lat !== 3 || got_e !== 1'b1) begin
      miscompares++;
      $display("FAIL err_word_misaligned: got lat=%0d err=%b, expected 3/1", got_lat, got_e);
    end
    txn(0, 1'b1, 2'd2, 32'h20, 32'h0);
    vectors++;
    if (got_e !== 1'b0 || got_d !== exp_dout[0]) begin
      miscompares++;
      $display("FAIL err_ram_unchanged: got err=%b data=%h, expected 0/%h", got_e, got_d, exp_dout[0]);
    end
    txn(0, 1'b1, 2'd1, 32'h03, 32'h0);
    vectors++;
    if (got_e !== 1'b1 || got_d !== 32'd0) begin
      miscompares++;
      $display("FAIL err_half_misaligned: got err=%b data=%h, expected 1/00000000", got_e, got_d);
    end
    txn(0, 1'b1, 2'd3, 32'h40, 32'h0);
    vectors++;
    if (got_e !== 1'b1) begin
      miscompares++;
      $display("FAIL err_ds11: got err=%b expected 1", got_e);
    end
    txn(0, 1'b0, 2'd2, 32'h100, 32'hCAFEF00D);
    vectors++;
    if (got_e !== 1'b1) begin
      miscompares++;
      $display("FAIL err_range_write: got err=%b expected 1", got_e);
    end
    txn(0, 1'b1, 2'd2, 32'h100, 32'h0);
    vectors++;
    if (got_e !== 1'b1 || got_d !== 32'd0) begin
      miscompares++;
      $display("FAIL err_range_read: got err=%b data=%h, expected 1/00000000", got_e, got_d);
    end
    txn(0, 1'b1, 2'd2, 32'h00, 32'h0);
    vectors++;
    if (got_d !== exp_dout[0]) begin
      miscompares++;
      $display("FAIL err_no_alias_write: got %h expected %h", got_d, exp_dout[0]);
    end
  endtask

  task automatic test_hold();
    int lat;
    ref_access(0, 1'b1, 2'd2, 32'h10, 32'h0, exp_e);
    @(negedge clk);
    rw = 1'b1; ds = 2'd2; addr = 32'h10; mov[0] = 1'b1;
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      @(posedge clk); #1;
      if (moc[0]) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL hold_latency: got %0d expected 3", lat);
    end
    addr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (moc[0] !== 1'b1 || dout[0] !== exp_dout[0]) begin
        miscompares++;
        $display("FAIL hold_done cycle %0d: got moc=%b data=%h, expected 1/%h", i, moc[0], dout[0], exp_dout[0]);
      end
    end
    @(negedge clk);
    mov[0] = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (moc[0] !== 1'b0 || dout[0] !== exp_dout[0]) begin
      miscompares++;
      $display("FAIL hold_release: got moc=%b data=%h, expected 0/%h", moc[0], dout[0], exp_dout[0]);
    end
    $display("txn dut=0 RD held in DONE addr=00000010 data=%h", dout[0]);
  endtask

  task automatic test_abort();
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      rw = 1'b0; ds = 2'd2; addr = 32'h30;
      wdata = ~{ref_mem[d][48], ref_mem[d][49], ref_mem[d][50], ref_mem[d][51]};
      mov[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mov[d] = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        vectors++;
        if (moc[d] !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_moc dut=%0d cycle %0d: got %b expected 0", d, i, moc[d]);
        end
      end
      $display("txn dut=%0d WR aborted addr=00000030 wdata=%h", d, wdata);
      txn(d, 1'b1, 2'd2, 32'h30, 32'h0);
      vectors++;
      if (got_d !== exp_dout[d]) begin
        miscompares++;
        $display("FAIL abort_no_commit dut=%0d: got %h expected %h", d, got_d, exp_dout[d]);
      end
    end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    rw = 1'b0; ds = 2'd2; addr = 32'h34;
    wdata = ~{ref_mem[1][52], ref_mem[1][53], ref_mem[1][54], ref_mem[1][55]};
    mov[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    srst = 1'b1;
    mov[1] = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (moc[d] !== 1'b0 || dout[d] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_busy dut=%0d: got moc=%b data=%h, expected 0/00000000", d, moc[d], dout[d]);
      end
      exp_dout[d] = 32'd0;
    end
    @(negedge clk);
    srst = 1'b0;
    $display("txn dut=1 WR reset in BUSY addr=00000034 wdata=%h", wdata);
    txn(1, 1'b1, 2'd2, 32'h34, 32'h0);
    vectors++;
    if (got_d !== exp_dout[1]) begin
      miscompares++;
      $display("FAIL reset_busy_no_write: got %h expected %h", got_d, exp_dout[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] val;
    val = $urandom;
    txn(1, 1'b0, 2'd2, 32'h80, val);
    vectors++;
    if (got_lat !== 1 || got_e !== 1'b0) begin
      miscompares++;
      $display("FAIL ws0_latency: got lat=%0d err=%b, expected 1/0", got_lat, got_e);
    end
    txn(1, 1'b1, 2'd2, 32'h80, 32'h0);
    vectors++;
    if (got_d !== val || got_lat !== 1) begin
      miscompares++;
      $display("FAIL ws0_back_to_back: got data=%h lat=%0d, expected %h/1", got_d, got_lat, val);
    end
  endtask

  task automatic test_random();
    int d, n, r;
    logic rw_v;
    logic [1:0] ds_v;
    logic [31:0] a;
    for (int k = 0; k < 150; k++) begin
      d = int'($urandom_range(0, 1));
      rw_v = 1'($urandom);
      ds_v = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      n = 1 << ds_v;
      r = int'($urandom_range(0, 9));
      if (r == 0) a = $urandom;
      else if (r == 1) a = 32'h100 + 32'($urandom_range(0, 255));
      else begin
        a = 32'($urandom_range(0, 255));
        if (r < 8 && ds_v != 2'd3) a = a & ~32'(n - 1);
      end
      txn(d, rw_v, ds_v, a, $urandom);
      vectors++;
      if (got_lat !== exp_lat[d] || got_e !== exp_e || got_d !== exp_dout[d] || got_rel !== 1'b1) begin
        miscompares++;
        $display("FAIL random%0d dut=%0d: got lat=%0d err=%b data=%h rel=%b, expected %0d/%b/%h/1",
                 k, d, got_lat, got_e, got_d, got_rel, exp_lat[d], exp_e, exp_dout[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_basic();
    test_errors();
    test_hold();
    test_abort();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the control unit's memory handshake (MOV/RW/DS out, MOC back).
- Latches a request from MAR/MDR, inserts programmable wait states, and performs a byte, halfword or word access on an internal byte-addressed, big-endian RAM.
- Answers with MOC using a four-phase handshake; flags misaligned or out-of-range accesses on ERR.
- Sits between the datapath's MAR/MDR and the instruction/data memory; replaces the ideal memory model used by datapath benches.

Parameters:
- ADDR_W, 8, byte-address width of the internal RAM (depth 2^ADDR_W bytes).
- WAIT_STATES, 2, extra cycles between request capture and MOC assertion (0..15).

Ports:
- CLK  input  1  clock, all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- MOV  input  1  memory operation valid from the control unit; held high until MOC is seen.
- RW  input  1  1 = read, 0 = write.
- DS  input  2  data size: 00 byte, 01 halfword, 10 word, 11 reserved (error).
- ADDR  input  32  byte address from MAR.
- DATA_IN  input  32  write data from MDR, right-justified for byte and halfword.
- DATA_OUT  output  32  read data, zero-extended, right-justified; registered.
- MOC  output  1  memory operation complete; registered.
- ERR  output  1  access error, valid while MOC = 1; registered.

Behaviour:
- Reset (RESET = 1 at an edge):
  - State goes to IDLE; MOC = 0, ERR = 0, DATA_OUT = 0, wait counter = 0.
  - RAM contents are unchanged; RESET has priority over everything.
- State machine (IDLE, BUSY, DONE):
  - IDLE: MOV = 1 at an edge latches RW, DS, ADDR and DATA_IN, loads counter = WAIT_STATES, and moves to BUSY. Later input changes are ignored until the return to IDLE.
  - BUSY: counter != 0 decrements it. Counter == 0 commits the access, sets MOC = 1 and moves to DONE.
  - DONE: MOC, ERR and DATA_OUT hold. MOV = 0 at an edge clears MOC and ERR and returns to IDLE; DATA_OUT keeps its last value.
- Latency: MOV is first sampled high at edge k; MOC is high after edge k+WAIT_STATES+1. With WAIT_STATES = 0, MOC is high after edge k+1.
- Minimum spacing: a new request is captured no earlier than the edge after MOV was sampled low in DONE, so back-to-back accesses need MOV low for at least one edge.
- Addressing is big-endian. Byte at address A is mem[A]:
  - Halfword at A is {mem[A], mem[A+1]}.
  - Word at A is {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
  - Only ADDR[ADDR_W-1:0] indexes the RAM.
- Reads: DATA_OUT = addressed data, zero-extended to 32 bits.
- Writes: only the addressed bytes change; DATA_IN[7:0] / [15:0] / [31:0] is the source; DATA_OUT is unchanged.
- Commit: the write or read happens at the edge that raises MOC. A following read of the same address returns the new data.
- Errors, with ERR = 1 and MOC asserted normally:
  - Any of the following is an error: halfword with ADDR[0] = 1; word with ADDR[1:0] != 0; DS = 11; ADDR[31:ADDR_W] != 0.
  - On an erroneous read, DATA_OUT = 0.
  - On an erroneous write, no RAM byte is modified.
- Protocol violation: MOV = 0 sampled in BUSY aborts the access, returns to IDLE, does not commit, and leaves MOC = 0.
- Reset in BUSY: no commit. Reset in DONE: the already committed write stays.
- Wait counter: 4 bits, never wraps because it is only loaded and decremented to 0.

Test Plan:
- Reset, then word write 0xDEADBEEF to 0x10 with WAIT_STATES = 2 -> MOC rises 3 edges after MOV is sampled, ERR = 0. Then word read 0x10 -> DATA_OUT = 0xDEADBEEF.
- Byte reads of 0x10..0x13 after the above -> 0x000000DE, 0x000000AD, 0x000000BE, 0x000000EF. Halfword read 0x12 -> 0x0000BEEF.
- Byte write 0x55 to 0x11, then word read 0x10 -> 0xDE55BEEF; other bytes unchanged.
- Misaligned cases:
  - Word write to 0x21 -> MOC = 1, ERR = 1; a later aligned read of 0x20 shows the RAM unchanged.
  - Halfword read at 0x03 -> ERR = 1, DATA_OUT = 0.
  - DS = 11 -> ERR = 1.
  - Address 0x100 with ADDR_W = 8 -> ERR = 1.
- Handshake boundaries:
  - MOV held high in DONE for 5 cycles -> MOC stays high, no second access.
  - MOV dropped one edge into BUSY -> MOC never rises and the write is not committed.
  - RESET asserted in BUSY -> MOC = 0, DATA_OUT = 0, no write.
- WAIT_STATES = 0 -> MOC high one edge after MOV is sampled. Back-to-back write then read of the same address with a single MOV-low edge between them -> the read returns the written data.
